// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side handshake bundle for the direct-mapped icache.
// slave = the cache, master = fetch stage plus memory controller.
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave  (input  imemREN, imemaddr, flush, iwait, iload,
                  output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, flush, iwait, iload,
                  input  ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one word per frame, with a
// single-word miss fill through the memory controller and hit/miss counters.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_direct_if.slave   bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e                       state_q, state_d;
  logic [SETS-1:0]              valid_q, valid_d;
  logic [SETS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [SETS-1:0][31:0]        data_q, data_d;
  logic [31:0]                  maddr_q, maddr_d;
  logic [CNT_W-1:0]             hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit;
  logic             unused_addr_lsb;

  assign req_idx         = bus.imemaddr[IDX+1:2];
  assign req_tag         = bus.imemaddr[31:IDX+2];
  assign fill_idx        = maddr_q[IDX+1:2];
  assign fill_tag        = maddr_q[31:IDX+2];
  assign unused_addr_lsb = ^{bus.imemaddr[1:0], maddr_q[1:0]};

  assign hit = (state_q == IDLE) && bus.imemREN && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    maddr_d      = maddr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_q[req_idx];
          hit_cnt_d    = hit_cnt_q + CNT_W'(1);
        end else if (bus.imemREN) begin
          maddr_d    = {bus.imemaddr[31:2], 2'b00};
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d    = FETCH;
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = maddr_q;
        // A flush aborts the fetch outright, even if the word arrives now.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (!bus.iwait) begin
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = fill_tag;
          data_d[fill_idx]  = bus.iload;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Invalidate takes effect at the edge; this cycle's hit uses old contents.
    if (bus.flush) valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      maddr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      maddr_q    <= maddr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/data are qualified by valid_q, so they carry no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed cycle table followed by random traffic
// checked against a frame-level reference model.
module tb_icache_direct;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] hit_count, miss_count;

  icache_direct_if bus ();

  icache_direct #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ren;
    logic [31:0] addr;
    logic        fl, wt;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_h, e_m;
  } vec_t;

  function automatic vec_t mk(input logic rst, ren, input logic [31:0] addr,
                              input logic fl, wt, input logic [31:0] ld,
                              input logic eh, input logic [31:0] el,
                              input logic er, input logic [31:0] ea,
                              input logic [31:0] ch, cm);
    vec_t r;
    r.rst = rst; r.ren = ren; r.addr = addr; r.fl = fl; r.wt = wt; r.ld = ld;
    r.e_hit = eh; r.e_load = el; r.e_iren = er; r.e_iaddr = ea;
    r.e_h = ch; r.e_m = cm;
    return r;
  endfunction

  // Reference model: frames hold the full word address of the cached line.
  bit          m_valid[16];
  logic [29:0] m_line[16];
  logic [31:0] m_word[16];
  bit          m_fetch;
  logic [31:0] m_pend;
  logic [31:0] m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_fetch = 0; m_pend = 0; m_hits = 0; m_misses = 0;
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  vec_t tbl[35];

  initial begin
    logic [31:0] a;
    logic        r, rn, f, w;
    logic [31:0] ld;
    int          i;
    logic        e_hit, e_iren;
    logic [31:0] e_load, e_iaddr;
    bit          model_ok;

    tbl[0]  = mk(1,0,32'h0,  0,0,32'h0,        0,32'h0,        0,32'h0,  0,0);
    tbl[1]  = mk(0,1,32'h40, 0,0,32'h0,        0,32'h0,        0,32'h0,  0,0);
    tbl[2]  = mk(0,1,32'h40, 0,1,32'h0,        0,32'h0,        1,32'h40, 0,1);
    tbl[3]  = mk(0,1,32'h40, 0,1,32'h0,        0,32'h0,        1,32'h40, 0,1);
    tbl[4]  = mk(0,1,32'h40, 0,1,32'h0,        0,32'h0,        1,32'h40, 0,1);
    tbl[5]  = mk(0,1,32'h40, 0,0,32'h8C220004, 0,32'h0,        1,32'h40, 0,1);
    tbl[6]  = mk(0,1,32'h40, 0,0,32'h0,        1,32'h8C220004, 0,32'h0,  0,1);
    tbl[7]  = mk(0,1,32'h40, 0,0,32'h0,        1,32'h8C220004, 0,32'h0,  1,1);
    tbl[8]  = mk(0,1,32'h440,0,0,32'h0,        0,32'h0,        0,32'h0,  2,1);
    tbl[9]  = mk(0,1,32'h440,0,0,32'h11110440, 0,32'h0,        1,32'h440,2,2);
    tbl[10] = mk(0,1,32'h440,0,0,32'h0,        1,32'h11110440, 0,32'h0,  2,2);
    tbl[11] = mk(0,1,32'h40, 0,0,32'h0,        0,32'h0,        0,32'h0,  3,2);
    tbl[12] = mk(0,1,32'h40, 0,0,32'h8C220004, 0,32'h0,        1,32'h40, 3,3);
    tbl[13] = mk(0,1,32'h40, 0,0,32'h0,        1,32'h8C220004, 0,32'h0,  3,3);
    tbl[14] = mk(0,1,32'h40, 1,0,32'h0,        1,32'h8C220004, 0,32'h0,  4,3);
    tbl[15] = mk(0,1,32'h40, 0,0,32'h0,        0,32'h0,        0,32'h0,  5,3);
    tbl[16] = mk(0,1,32'h40, 0,0,32'h8C220004, 0,32'h0,        1,32'h40, 5,4);
    tbl[17] = mk(0,0,32'h40, 0,0,32'h0,        0,32'h0,        0,32'h0,  5,4);
    tbl[18] = mk(0,1,32'h80, 0,0,32'h0,        0,32'h0,        0,32'h0,  5,4);
    tbl[19] = mk(0,1,32'h100,0,1,32'h0,        0,32'h0,        1,32'h80, 5,5);
    tbl[20] = mk(0,1,32'h100,0,0,32'h22220080, 0,32'h0,        1,32'h80, 5,5);
    tbl[21] = mk(0,1,32'h100,0,0,32'h0,        0,32'h0,        0,32'h0,  5,5);
    tbl[22] = mk(0,1,32'h100,0,0,32'h33330100, 0,32'h0,        1,32'h100,5,6);
    tbl[23] = mk(0,1,32'h100,0,0,32'h0,        1,32'h33330100, 0,32'h0,  5,6);
    tbl[24] = mk(0,1,32'h44, 0,0,32'h0,        0,32'h0,        0,32'h0,  6,6);
    tbl[25] = mk(0,1,32'h44, 1,0,32'h44444444, 0,32'h0,        1,32'h44, 6,7);
    tbl[26] = mk(0,1,32'h44, 0,0,32'h0,        0,32'h0,        0,32'h0,  6,7);
    tbl[27] = mk(0,1,32'h44, 0,1,32'h0,        0,32'h0,        1,32'h44, 6,8);
    tbl[28] = mk(1,1,32'h44, 0,1,32'h0,        0,32'h0,        1,32'h44, 6,8);
    tbl[29] = mk(0,0,32'h0,  0,0,32'h0,        0,32'h0,        0,32'h0,  0,0);
    tbl[30] = mk(0,1,32'h40, 0,0,32'h0,        0,32'h0,        0,32'h0,  0,0);
    tbl[31] = mk(0,1,32'h40, 0,0,32'h8C220004, 0,32'h0,        1,32'h40, 0,1);
    tbl[32] = mk(0,1,32'h44, 0,0,32'h0,        0,32'h0,        0,32'h0,  0,1);
    tbl[33] = mk(0,1,32'h44, 0,0,32'h44444444, 0,32'h0,        1,32'h44, 0,2);
    tbl[34] = mk(0,1,32'h44, 0,0,32'h0,        1,32'h44444444, 0,32'h0,  0,2);

    RST = 1'b1; bus.imemREN = 0; bus.imemaddr = 0; bus.flush = 0;
    bus.iwait = 0; bus.iload = 0;
    repeat (2) @(posedge CLK);

    for (i = 0; i < 35; i++) begin
      #1;
      RST = tbl[i].rst; bus.imemREN = tbl[i].ren; bus.imemaddr = tbl[i].addr;
      bus.flush = tbl[i].fl; bus.iwait = tbl[i].wt; bus.iload = tbl[i].ld;
      @(negedge CLK);
      check($sformatf("row%0d ihit", i),       {31'b0, bus.ihit}, {31'b0, tbl[i].e_hit});
      check($sformatf("row%0d imemload", i),   bus.imemload,      tbl[i].e_load);
      check($sformatf("row%0d iREN", i),       {31'b0, bus.iREN}, {31'b0, tbl[i].e_iren});
      check($sformatf("row%0d iaddr", i),      bus.iaddr,         tbl[i].e_iaddr);
      check($sformatf("row%0d hit_count", i),  hit_count,         tbl[i].e_h);
      check($sformatf("row%0d miss_count", i), miss_count,        tbl[i].e_m);
      @(posedge CLK);
    end

    // Random traffic over a small address pool so frames collide and re-hit.
    model_ok = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      #1;
      r  = (c == 0) || ($urandom_range(0, 199) == 0);
      rn = ($urandom_range(0, 9) < 8);
      f  = ($urandom_range(0, 39) == 0);
      w  = $urandom_range(0, 1);
      a  = {24'h0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      ld = bus.iREN ? memfn(bus.iaddr) : $urandom;
      RST = r; bus.imemREN = rn; bus.imemaddr = a; bus.flush = f;
      bus.iwait = w; bus.iload = ld;
      @(negedge CLK);
      e_hit = 0; e_load = 0; e_iren = 0; e_iaddr = 0;
      if (!m_fetch) begin
        if (rn && m_valid[a[5:2]] && m_line[a[5:2]] == a[31:2]) begin
          e_hit = 1; e_load = m_word[a[5:2]];
        end
      end else begin
        e_iren = 1; e_iaddr = m_pend;
      end
      if (model_ok) begin
        check("rnd ihit",       {31'b0, bus.ihit}, {31'b0, e_hit});
        check("rnd imemload",   bus.imemload,      e_load);
        check("rnd iREN",       {31'b0, bus.iREN}, {31'b0, e_iren});
        check("rnd iaddr",      bus.iaddr,         e_iaddr);
        check("rnd hit_count",  hit_count,         m_hits);
        check("rnd miss_count", miss_count,        m_misses);
      end
      if (r) begin
        model_reset();
        model_ok = 1;
      end else begin
        if (!m_fetch) begin
          if (e_hit) m_hits++;
          else if (rn) begin
            m_misses++; m_fetch = 1; m_pend = {a[31:2], 2'b00};
          end
        end else if (f) begin
          m_fetch = 0;
        end else if (!w) begin
          m_valid[m_pend[5:2]] = 1;
          m_line[m_pend[5:2]]  = m_pend[31:2];
          m_word[m_pend[5:2]]  = ld;
          m_fetch = 0;
        end
        if (f) for (int k = 0; k < 16; k++) m_valid[k] = 0;
      end
      @(posedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
